sig_storage_window: RTL and testbench

Per-channel playback store, the next generation of the channel-unit signal storage. Fills a windowed region of an internal RAM from an upstream BRAM/DMA source using a req/resp handshake. Plays the region back to the channel timing logic in one-shot or loop mode. Width, depth and inter-request delay are parametrised; playback wraps within the configured window, not the whole memory.

---
 rtl/sig_storage_window.sv | 190 +++++++++++++++++++
 tb/tb_sig_storage_window.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_storage_window.sv
// Windowed playback store: fills [base, base+len) of a local RAM from a req/resp source and
// plays it back one word per advance edge, in one-shot or looping mode.
module sig_storage_window #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned DELAY      = 5,
  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [AW-1:0]         base_addr,
  input  logic [AW:0]           num_words,
  input  logic                  store_config,
  input  logic                  fetch,
  output logic                  req_valid,
  input  logic                  req_ready,
  input  logic                  rsp_valid,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  fill_done,
  output logic [AW:0]           fill_count,
  input  logic                  loop_mode,
  input  logic                  play_restart,
  input  logic                  play_advance,
  output logic [DATA_WIDTH-1:0] play_data,
  output logic                  play_last,
  output logic                  play_done
);

  localparam int unsigned CW = (DELAY > 0) ? $clog2(DELAY + 1) : 1;

  localparam logic [AW:0]   DepthW  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   OneW    = (AW + 1)'(1);
  localparam logic [AW-1:0] PtrMax  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PtrOne  = AW'(1);
  localparam logic [CW-1:0] DelayW  = CW'(DELAY);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StReq   = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StDelay = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [AW-1:0]         base_q;
  logic [AW:0]           len_q;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]           fill_count_q, fill_count_d;
  logic [CW-1:0]         dly_cnt_q, dly_cnt_d;
  logic                  mem_we;

  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  play_done_q, play_done_d;
  logic                  adv_q;
  logic                  adv_edge;
  logic [DATA_WIDTH-1:0] play_data_q;

  logic [AW-1:0]         base_norm;
  logic [AW:0]           len_clamp;
  logic [AW:0]           last_sum;
  logic [AW-1:0]         last_addr;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  function automatic logic [AW-1:0] inc_wrap(input logic [AW-1:0] ptr);
    return (ptr == PtrMax) ? '0 : ptr + PtrOne;
  endfunction

  // Base addresses past the end of a non-power-of-two RAM fold back into range.
  always_comb begin
    base_norm = base_addr;
    if ({1'b0, base_addr} >= DepthW) base_norm = AW'({1'b0, base_addr} - DepthW);
    len_clamp = (num_words > DepthW) ? DepthW : num_words;
  end

  always_comb begin
    last_sum  = {1'b0, base_q} + len_q - OneW;
    last_addr = (last_sum >= DepthW) ? AW'(last_sum - DepthW) : last_sum[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= '0;
      len_q  <= '0;
    end else if (store_config && (state_q == StIdle)) begin
      base_q <= base_norm;
      len_q  <= len_clamp;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    fill_count_d = fill_count_q;
    dly_cnt_d    = dly_cnt_q;
    mem_we       = 1'b0;
    req_valid    = 1'b0;
    case (state_q)
      StIdle: begin
        wr_ptr_d = base_q;
        if (fetch) state_d = (len_q != '0) ? StReq : StDone;
      end
      StReq: begin
        req_valid = fetch;
        if (!fetch) state_d = StIdle;
        else if (req_ready) state_d = StWait;
      end
      StWait: begin
        // An outstanding request is always completed, even if fetch has dropped.
        if (rsp_valid) begin
          mem_we       = 1'b1;
          wr_ptr_d     = inc_wrap(wr_ptr_q);
          fill_count_d = fill_count_q + OneW;
          dly_cnt_d    = '0;
          if (fill_count_d == len_q) state_d = StDone;
          else if (!fetch) state_d = StIdle;
          else state_d = StDelay;
        end
      end
      StDelay: begin
        if (dly_cnt_q == DelayW) begin
          dly_cnt_d = '0;
          state_d   = fetch ? StReq : StIdle;
        end else begin
          dly_cnt_d = dly_cnt_q + CntOne;
        end
      end
      StDone: begin
        if (!fetch) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (state_d == StIdle) fill_count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      fill_count_q <= '0;
      dly_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_count_q <= fill_count_d;
      dly_cnt_q    <= dly_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[wr_ptr_q] <= rsp_data;
  end

  assign adv_edge = play_advance && !adv_q;

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    play_done_d = play_done_q;
    if (play_restart) begin
      rd_ptr_d    = base_q;
      play_done_d = 1'b0;
    end else if (adv_edge && (len_q != '0)) begin
      if (rd_ptr_q != last_addr) rd_ptr_d = inc_wrap(rd_ptr_q);
      else if (loop_mode) rd_ptr_d = base_q;
      else play_done_d = 1'b1;
    end
  end

  // Read-first RAM port: a same-cycle write to rd_ptr shows up one read later.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      play_done_q <= 1'b0;
      adv_q       <= 1'b0;
      play_data_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      play_done_q <= play_done_d;
      adv_q       <= play_advance;
      play_data_q <= mem[rd_ptr_q];
    end
  end

  assign fill_done  = (state_q == StDone);
  assign fill_count = fill_count_q;
  assign play_data  = play_data_q;
  assign play_last  = (len_q != '0) && (rd_ptr_q == last_addr);
  assign play_done  = play_done_q;

endmodule

// File: tb/tb_sig_storage_window.sv
// Directed bench for sig_storage_window: fill handshakes, windowed wrap, one-shot/loop playback.
module tb_sig_storage_window;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned DELAY = 2;
  localparam int unsigned AW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic          store_config;
  logic          fetch;
  logic          req_valid;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          fill_done;
  logic [AW:0]   fill_count;
  logic          loop_mode;
  logic          play_restart;
  logic          play_advance;
  logic [DW-1:0] play_data;
  logic          play_last;
  logic          play_done;

  int checks = 0;
  int errors = 0;
  int n_hs;

  localparam logic [DW-1:0] DA = 32'hA000_0000;
  localparam logic [DW-1:0] DB = 32'hB000_0000;
  localparam logic [DW-1:0] DC = 32'hC000_0000;
  localparam logic [DW-1:0] DD = 32'hD000_0000;

  sig_storage_window #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .DELAY     (DELAY)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .base_addr   (base_addr),
    .num_words   (num_words),
    .store_config(store_config),
    .fetch       (fetch),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .fill_done   (fill_done),
    .fill_count  (fill_count),
    .loop_mode   (loop_mode),
    .play_restart(play_restart),
    .play_advance(play_advance),
    .play_data   (play_data),
    .play_last   (play_last),
    .play_done   (play_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [AW-1:0] b, input logic [AW:0] n);
    base_addr    = b;
    num_words    = n;
    store_config = 1'b1;
    tick();
    store_config = 1'b0;
  endtask

  task automatic restart();
    play_restart = 1'b1;
    tick();
    play_restart = 1'b0;
    tick();
  endtask

  task automatic adv();
    play_advance = 1'b1;
    tick();
    play_advance = 1'b0;
    tick();
  endtask

  // Source model: answers each accepted request two cycles later with d0 + index.
  task automatic run_fill(input logic [DW-1:0] d0, input int drop_hs, output int hs);
    int   rsp_due  = -10;
    int   last_rsp = -1;
    int   k        = 0;
    logic prev_rv  = 1'b0;
    logic fin      = 1'b0;
    logic drop_pend = 1'b0;
    hs = 0;
    for (int c = 0; c < 400; c++) begin
      if (drop_pend) begin
        fetch     = 1'b0;
        drop_pend = 1'b0;
      end
      rsp_valid = (c == rsp_due);
      rsp_data  = d0 + DW'(k);
      if (rsp_valid) begin
        last_rsp = c;
        k++;
      end
      if (req_valid && !prev_rv && (last_rsp >= 0))
        chk("req_gap", 64'((c - last_rsp) >= int'(DELAY + 1)), 64'd1);
      prev_rv = req_valid;
      if (req_valid && req_ready) begin
        hs++;
        rsp_due = c + 2;
        if (hs == drop_hs) drop_pend = 1'b1;
      end
      if (fill_done || (!fetch && (c > rsp_due + 1))) begin
        fin = 1'b1;
        break;
      end
      tick();
    end
    rsp_valid = 1'b0;
    chk("fill_end", 64'(fin), 64'd1);
  endtask

  initial begin
    reset        = 1'b1;
    base_addr    = '0;
    num_words    = '0;
    store_config = 1'b0;
    fetch        = 1'b0;
    req_ready    = 1'b1;
    rsp_valid    = 1'b0;
    rsp_data     = '0;
    loop_mode    = 1'b0;
    play_restart = 1'b0;
    play_advance = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_fill_done", 64'(fill_done), 64'd0);
    chk("rst_fill_count", 64'(fill_count), 64'd0);
    chk("rst_play_data", 64'(play_data), 64'd0);
    chk("rst_play_last", 64'(play_last), 64'd0);
    chk("rst_play_done", 64'(play_done), 64'd0);

    // Basic fill of 3..6
    cfg(4'd3, 5'd4);
    fetch = 1'b1;
    run_fill(DA, 0, n_hs);
    chk("fill_hs", 64'(n_hs), 64'd4);
    chk("fill_done", 64'(fill_done), 64'd1);
    chk("fill_count", 64'(fill_count), 64'd4);
    tick();
    chk("done_hold", 64'(fill_done), 64'd1);
    chk("done_req", 64'(req_valid), 64'd0);
    fetch = 1'b0;
    tick();
    chk("idle_fill_done", 64'(fill_done), 64'd0);
    chk("idle_fill_count", 64'(fill_count), 64'd0);
    loop_mode = 1'b0;
    restart();
    chk("play_a0", 64'(play_data), 64'(DA));
    for (int k = 1; k < 4; k++) begin
      adv();
      chk("play_a", 64'(play_data), 64'(DA + DW'(k)));
    end
    chk("play_a_last", 64'(play_last), 64'd1);

    // Window wrapping the end of memory: 14,15,0,1
    cfg(4'd14, 5'd4);
    fetch = 1'b1;
    run_fill(DB, 0, n_hs);
    chk("wrap_hs", 64'(n_hs), 64'd4);
    fetch = 1'b0;
    tick();
    loop_mode = 1'b1;
    restart();
    chk("wrap_p0", 64'(play_data), 64'(DB));
    chk("wrap_last0", 64'(play_last), 64'd0);
    for (int i = 1; i <= 5; i++) begin
      adv();
      chk("wrap_data", 64'(play_data), 64'(DB + DW'(i % 4)));
      chk("wrap_last", 64'(play_last), 64'((i % 4) == 3));
    end

    // One-shot over 14,15,0
    cfg(4'd14, 5'd3);
    loop_mode = 1'b0;
    restart();
    chk("os_p0", 64'(play_data), 64'(DB));
    adv();
    chk("os_p1", 64'(play_data), 64'(DB + 32'd1));
    adv();
    chk("os_p2", 64'(play_data), 64'(DB + 32'd2));
    chk("os_last", 64'(play_last), 64'd1);
    chk("os_done_pre", 64'(play_done), 64'd0);
    adv();
    chk("os_hold", 64'(play_data), 64'(DB + 32'd2));
    chk("os_done", 64'(play_done), 64'd1);
    adv();
    chk("os_hold2", 64'(play_data), 64'(DB + 32'd2));
    chk("os_done2", 64'(play_done), 64'd1);
    restart();
    chk("os_restart_data", 64'(play_data), 64'(DB));
    chk("os_done_clr", 64'(play_done), 64'd0);

    // fetch dropped while the 3rd request is outstanding
    cfg(4'd5, 5'd8);
    fetch = 1'b1;
    run_fill(DC, 3, n_hs);
    chk("drop_hs", 64'(n_hs), 64'd3);
    chk("drop_count", 64'(fill_count), 64'd0);
    chk("drop_fill_done", 64'(fill_done), 64'd0);
    chk("drop_req", 64'(req_valid), 64'd0);
    rsp_data  = 32'hDEAD_BEEF;
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    tick();
    restart();
    chk("drop_w0", 64'(play_data), 64'(DC));
    adv();
    chk("drop_w1", 64'(play_data), 64'(DC + 32'd1));
    adv();
    chk("drop_w2", 64'(play_data), 64'(DC + 32'd2));

    // Advance held high steps once
    restart();
    play_advance = 1'b1;
    repeat (10) tick();
    play_advance = 1'b0;
    tick();
    chk("held_adv", 64'(play_data), 64'(DC + 32'd1));
    chk("held_done", 64'(play_done), 64'd0);

    // store_config while filling is ignored
    cfg(4'd0, 5'd2);
    req_ready = 1'b0;
    fetch     = 1'b1;
    tick();
    cfg(4'd9, 5'd1);
    req_ready = 1'b1;
    run_fill(DD, 0, n_hs);
    chk("cfg_hs", 64'(n_hs), 64'd2);
    chk("cfg_fill_done", 64'(fill_done), 64'd1);
    chk("cfg_fill_count", 64'(fill_count), 64'd2);
    fetch = 1'b0;
    tick();
    restart();
    chk("cfg_base", 64'(play_data), 64'(DD));
    chk("cfg_last0", 64'(play_last), 64'd0);
    adv();
    chk("cfg_w1", 64'(play_data), 64'(DD + 32'd1));
    chk("cfg_last1", 64'(play_last), 64'd1);

    // Length beyond DEPTH clamps: window 3..2 (wrapping), last = 2
    cfg(4'd3, 5'd20);
    restart();
    repeat (14) adv();
    chk("clamp_mid", 64'(play_last), 64'd0);
    adv();
    chk("clamp_last", 64'(play_last), 64'd1);
    chk("clamp_done", 64'(play_done), 64'd0);

    // Reset while requesting
    cfg(4'd0, 5'd4);
    req_ready = 1'b0;
    fetch     = 1'b1;
    tick();
    chk("rstreq_pre", 64'(req_valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstreq_req", 64'(req_valid), 64'd0);
    chk("rstreq_done", 64'(fill_done), 64'd0);
    chk("rstreq_count", 64'(fill_count), 64'd0);
    chk("rstreq_data", 64'(play_data), 64'd0);
    chk("rstreq_last", 64'(play_last), 64'd0);
    chk("rstreq_pdone", 64'(play_done), 64'd0);
    // Config cleared to len 0: fetch goes straight to DONE
    tick();
    chk("len0_done", 64'(fill_done), 64'd1);
    chk("len0_req", 64'(req_valid), 64'd0);
    fetch = 1'b0;
    tick();
    chk("len0_idle", 64'(fill_done), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
